// File: rtl/service_3_lap_stopwatch_if.sv
// rtl/service_3_lap_stopwatch_if.sv - front-panel bundle for the service-3 lap stopwatch
//
// Purpose: groups the switch, buttons, display select and status outputs of
// the lap stopwatch so they travel as one port.
// Signals:
//   SPDT       service enable switch (level)
//   push_m     start/pause button, debounced level
//   push_l     lap/clear button, debounced level
//   show_lap   1 = display stored lap lap_sel, 0 = live time
//   lap_sel    lap index to display (LW bits)
//   segments   BCD {sec_tens, sec_units, hun_tens, hun_units}
//   running    high while counting
//   lap_count  stored laps, 0..2**LW
//   lap_full   all lap registers used
//   ovf        sticky saturation flag
//   finish     registered copy of !SPDT
// Modports: master drives the panel inputs, slave is the stopwatch.
`timescale 1ns/1ps
interface service_3_lap_stopwatch_if #(
  parameter int LW = 2
);
  logic          SPDT;
  logic          push_m;
  logic          push_l;
  logic          show_lap;
  logic [LW-1:0] lap_sel;
  logic [15:0]   segments;
  logic          running;
  logic [LW:0]   lap_count;
  logic          lap_full;
  logic          ovf;
  logic          finish;

  modport master (
    output SPDT, push_m, push_l, show_lap, lap_sel,
    input  segments, running, lap_count, lap_full, ovf, finish
  );

  modport slave (
    input  SPDT, push_m, push_l, show_lap, lap_sel,
    output segments, running, lap_count, lap_full, ovf, finish
  );
endinterface

// File: rtl/service_3_lap_stopwatch.sv
// rtl/service_3_lap_stopwatch.sv - BCD lap stopwatch with lap browsing and overflow flag
//
// Purpose: counts hundredths/seconds in BCD up to 99.99, stores up to
// LAP_DEPTH lap times, and shows live time or a stored lap on 4 digits.
// Ports:
//   clk    main clock (CLOCK_FREQ Hz, multiple of 100)
//   reset  asynchronous active-high, clears all state
//   bus    service_3_lap_stopwatch_if.slave (switch, buttons, display, status)
`timescale 1ns/1ps
module service_3_lap_stopwatch #(
  parameter int CLOCK_FREQ = 100,
  parameter int LAP_DEPTH  = 4
) (
  input logic                      clk,
  input logic                      reset,
  service_3_lap_stopwatch_if.slave bus
);
  localparam int TICK_DIV = CLOCK_FREQ / 100;
  localparam int LW       = $clog2(LAP_DEPTH);
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   lap_q [LAP_DEPTH];
  logic [15:0]   lap_d [LAP_DEPTH];
  logic [LW:0]   lap_count_q, lap_count_d;
  logic          ovf_q, ovf_d;
  logic          m_prev_q, l_prev_q;
  logic [15:0]   seg_q, seg_d;
  logic          finish_q;

  logic m_press, l_press, tick_point, lap_full, clear_all;

  // One-hundredth BCD increment; the 99.99 case is handled by the caller.
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (r[7:4] != 4'd9) r[7:4] = r[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (r[11:8] != 4'd9) r[11:8] = r[11:8] + 4'd1;
        else begin
          r[11:8]  = 4'd0;
          r[15:12] = r[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign m_press    = bus.push_m & ~m_prev_q;
  assign l_press    = bus.push_l & ~l_prev_q;
  assign tick_point = (presc_q == PW'(TICK_DIV - 1));
  assign lap_full   = (lap_count_q == (LW+1)'(LAP_DEPTH));

  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    presc_d     = presc_q;
    lap_d       = lap_q;
    lap_count_d = lap_count_q;
    ovf_d       = ovf_q;
    clear_all   = 1'b0;

    if (!bus.SPDT) begin
      state_d   = S_IDLE;
      clear_all = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_READY;
          clear_all = 1'b1;
        end
        S_READY: begin
          if (m_press) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN: begin
          // A start/pause press wins over a simultaneous lap press and
          // freezes the prescaler where it is.
          if (m_press) begin
            state_d = S_PAUSE;
          end else begin
            // Lap captures the time as it was before this edge's tick.
            if (l_press && !lap_full) begin
              lap_d[lap_count_q[LW-1:0]] = time_q;
              lap_count_d                = lap_count_q + (LW+1)'(1);
            end
            if (tick_point) begin
              presc_d = '0;
              if (time_q == 16'h9999) begin
                ovf_d   = 1'b1;
                state_d = S_PAUSE;
              end else begin
                time_d = bcd_inc(time_q);
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        default: begin
          if (m_press) begin
            if (!ovf_q) state_d = S_RUN;
          end else if (l_press) begin
            state_d   = S_READY;
            clear_all = 1'b1;
          end
        end
      endcase
    end

    if (clear_all) begin
      time_d      = '0;
      presc_d     = '0;
      lap_count_d = '0;
      ovf_d       = 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) lap_d[i] = '0;
    end
  end

  always_comb begin
    seg_d = time_q;
    if (bus.show_lap) begin
      if ({1'b0, bus.lap_sel} < lap_count_q) seg_d = lap_q[bus.lap_sel];
      else                                   seg_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      time_q      <= '0;
      presc_q     <= '0;
      lap_count_q <= '0;
      ovf_q       <= 1'b0;
      m_prev_q    <= 1'b0;
      l_prev_q    <= 1'b0;
      seg_q       <= '0;
      finish_q    <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) lap_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      presc_q     <= presc_d;
      lap_count_q <= lap_count_d;
      ovf_q       <= ovf_d;
      m_prev_q    <= bus.push_m;
      l_prev_q    <= bus.push_l;
      seg_q       <= seg_d;
      finish_q    <= ~bus.SPDT;
      for (int i = 0; i < LAP_DEPTH; i++) lap_q[i] <= lap_d[i];
    end
  end

  assign bus.segments  = seg_q;
  assign bus.running   = (state_q == S_RUN);
  assign bus.lap_count = lap_count_q;
  assign bus.lap_full  = lap_full;
  assign bus.ovf       = ovf_q;
  assign bus.finish    = finish_q;
endmodule
